// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Shares one APB master port between NUM_REQ requesters using round-robin
// arbitration. One transfer is in flight at a time: IDLE -> SETUP -> ACCESS.
// A completion or timeout produces a one-cycle response pulse to the owner.
//
// Ports
//   pclk, preset            clock, synchronous active-high reset
//   req_valid/req_ready     per-requester request handshake (one-hot grant)
//   req_addr/write/wdata/strb  flattened per-requester transfer fields
//   rsp_valid/rsp_rdata/rsp_err  completion pulse, read data, error flag
//   psel..pstrb             APB master outputs
//   pready/prdata/pslverr   APB slave responses
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              psel,
  output logic                              penable,
  output logic [ADDR_WIDTH-1:0]             paddr,
  output logic                              pwrite,
  output logic [DATA_WIDTH-1:0]             pwdata,
  output logic [DATA_WIDTH/8-1:0]           pstrb,
  input  logic                              pready,
  input  logic [DATA_WIDTH-1:0]             prdata,
  input  logic                              pslverr
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]      strb_q, strb_d;
  logic [CNT_W-1:0]       wait_q, wait_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   grant_found;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]     grant_onehot;
  int unsigned            cand;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(last_q) + 32'd1 + k) % NUM_REQ;
      if (!grant_found && req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (grant_found) begin
      grant_onehot = NUM_REQ'(1) << grant_idx;
    end
  end

  // Grant is combinational and only offered while idle and out of reset.
  assign req_ready = (state_q == IDLE && !preset) ? grant_onehot : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    wait_d      = wait_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = SETUP;
          last_d  = grant_idx;
          owner_d = grant_idx;
          addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          write_d = req_write[grant_idx];
          // Reads latch zero data/strobes so the bus shows 0 for them.
          wdata_d = req_write[grant_idx] ?
                    req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
          strb_d  = req_write[grant_idx] ?
                    req_strb[grant_idx*STRB_W +: STRB_W] : '0;
          wait_d  = '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          wait_d      = '0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = write_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          wait_d      = '0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      wait_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);
  assign pwrite    = psel & write_q;
  assign pstrb     = psel ? strb_q : '0;
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one APB master port.
REQ-002 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 Parameter DATA_WIDTH, default 32, APB data width; DATA_WIDTH/8 strobe bits.
REQ-004 Parameter TIMEOUT, default 16, max ACCESS cycles awaiting pready (>=1).
REQ-005 One clock; reset is synchronous and active-high: pclk in 1, APB clock, all logic on rising edge.
REQ-006 preset in 1, synchronous active-high reset.
REQ-007 req_valid in NUM_REQ, per-requester transfer request.
REQ-008 req_ready out NUM_REQ, one-hot grant; request accepted on req_valid&req_ready.
REQ-009 req_addr in NUM_REQ*ADDR_WIDTH, flattened addresses, requester i at slice i.
REQ-010 req_write in NUM_REQ, 1=write, 0=read.
REQ-011 req_wdata in NUM_REQ*DATA_WIDTH, flattened write data.
REQ-012 req_strb in NUM_REQ*DATA_WIDTH/8, flattened write strobes.
REQ-013 rsp_valid out NUM_REQ, one-cycle completion pulse to owning requester.
REQ-014 rsp_rdata out DATA_WIDTH, read data, valid with rsp_valid.
REQ-015 rsp_err out 1, error flag (pslverr or timeout), valid with rsp_valid.
REQ-016 psel out 1; penable out 1; paddr out ADDR_WIDTH; pwrite out 1; pwdata out DATA_WIDTH; pstrb out DATA_WIDTH/8: APB master outputs.
REQ-017 pready in 1; prdata in DATA_WIDTH; pslverr in 1: APB slave responses.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-019 IDLE: if any req_valid, assert req_ready for the round-robin winner combinationally, latch its addr/write/wdata/strb and index, next state SETUP; else stay IDLE.
REQ-020 Round-robin: search starts at index (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-021 req_ready is zero outside IDLE; at most one bit set at any time.
REQ-022 SETUP (exactly one cycle): psel=1, penable=0, paddr/pwrite/pwdata/pstrb from latched values; next ACCESS.
REQ-023 ACCESS: psel=1, penable=1, outputs held stable; wait counter increments each cycle pready=0.
REQ-024 ACCESS with pready=1: rsp_valid[owner] pulses next cycle with rsp_rdata=prdata (reads; 0 for writes), rsp_err=pslverr; next IDLE.
REQ-025 ACCESS with pready=0 for TIMEOUT consecutive cycles: drop psel/penable, pulse rsp_valid[owner] with rsp_err=1, rsp_rdata=0; next IDLE.
REQ-026 Back-to-back: new grant possible in the IDLE cycle that follows completion; minimum 3 cycles per transfer (IDLE, SETUP, ACCESS).
REQ-027 pstrb driven 0 on reads; pwdata driven 0 on reads.
REQ-028 psel/penable/pwrite/pstrb are 0 in IDLE; paddr/pwdata hold last value.
REQ-029 Request withdrawal while not granted is legal and ignored; latched values unaffected by req_* changes after grant.
REQ-030 pready/pslverr/prdata ignored outside ACCESS.

Reset
REQ-031 preset=1 at any edge: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, last_grant=NUM_REQ-1.
REQ-032 Reset mid-transfer aborts without rsp_valid; first cycle after reset release is IDLE.

Verification
REQ-033 Single write: req_valid[2]=1, addr=0x10, wdata=0xA5A5A5A5, strb=0xF, pready=1 on first ACCESS -> psel cycle 1, penable cycle 2, rsp_valid[2] cycle 3, rsp_err=0.
REQ-034 Read with 3 wait states: req 0 read addr 0x20, pready low 3 ACCESS cycles then high with prdata=0x1234 -> 4 ACCESS cycles, rsp_rdata=0x1234.
REQ-035 All four requesting continuously -> grant order 0,1,2,3,0, no requester granted twice before others.
REQ-036 pready held 0 -> after 16 ACCESS cycles psel drops, rsp_valid pulses with rsp_err=1, rsp_rdata=0.
REQ-037 pslverr=1 with pready=1 on write -> rsp_err=1 for owning requester only.
REQ-038 preset asserted during ACCESS -> next cycle psel=0, penable=0, no rsp_valid; subsequent request granted to requester 0.
